// File: rtl/conv_pkg.sv
// Shared definitions for the convolution PE controller: FSM state type,
// default datapath constants and a counter-width helper.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int DEFAULT_WIDTH = 9;
  localparam int DEFAULT_K     = 3;

  // Bits needed to hold the values 0..n-1 (at least one bit).
  function automatic int cnt_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_pe_ctrl_if.sv
// Weight/pixel streams, PE-side strobes and the result port of the
// convolution PE controller, bundled for connection between blocks.
interface conv_pe_ctrl_if
  import conv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  // Valid/ready: a beat transfers on a rising edge where valid and ready are
  // both high; the source holds data stable while valid is high and ready
  // low. out_valid/out_data have no ready and must be taken when presented.
  logic               w_valid;
  logic [WIDTH-1:0]   w_data;
  logic               w_ready;
  logic               px_valid;
  logic [WIDTH-1:0]   px_data;
  logic               px_ready;
  logic [WIDTH-1:0]   pe_weight_in;
  logic               pe_wload;
  logic [WIDTH-1:0]   pe_data_in;
  logic               pe_en;
  logic [2*WIDTH-1:0] pe_data_out;
  logic               out_valid;
  logic [2*WIDTH-1:0] out_data;

  modport master (
    input  w_valid, w_data, px_valid, px_data, pe_data_out,
    output w_ready, px_ready, pe_weight_in, pe_wload, pe_data_in, pe_en,
           out_valid, out_data
  );

  modport slave (
    output w_valid, w_data, px_valid, px_data, pe_data_out,
    input  w_ready, px_ready, pe_weight_in, pe_wload, pe_data_in, pe_en,
           out_valid, out_data
  );

endinterface

// File: rtl/conv_valid_dly.sv
// Fixed-depth 1-bit shift register that carries the window-valid tag
// alongside the PE pipeline; advances every cycle.
module conv_valid_dly #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (!rst_n) sr <= '0;
        else        sr <= din;
      end
    end else begin : g_many
      always_ff @(posedge clk) begin
        if (!rst_n) sr <= '0;
        else        sr <= {sr[DEPTH-2:0], din};
      end
    end
  endgenerate

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/conv_pe_ctrl.sv
// Sequences one image through a convolution PE: loads K*K weights, streams
// pixels in raster order and flags results whose window lies inside the image.
module conv_pe_ctrl
  import conv_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int K      = DEFAULT_K,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 3,
  parameter int PE_LAT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output state_t         state_dbg,
  conv_pe_ctrl_if.master bus
);

  localparam int KK  = K * K;
  localparam int WCW = cnt_bits(KK);
  localparam int CW  = cnt_bits(IMG_W);
  localparam int RW  = cnt_bits(IMG_H);
  localparam int DCW = cnt_bits(PE_LAT + 1);

  localparam logic [WCW-1:0] W_LAST    = WCW'(KK - 1);
  localparam logic [CW-1:0]  COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0]  ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0]  COL_FIRST = CW'(K - 1);
  localparam logic [RW-1:0]  ROW_FIRST = RW'(K - 1);
  localparam logic [DCW-1:0] D_LAST    = DCW'(PE_LAT);

  state_t             state;
  logic [WCW-1:0]     w_cnt;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic [DCW-1:0]     drain_cnt;
  logic               w_ready_q;
  logic               px_ready_q;
  logic [WIDTH-1:0]   pe_weight_q;
  logic               pe_wload_q;
  logic [WIDTH-1:0]   pe_data_q;
  logic               pe_en_q;
  logic               out_valid_q;
  logic [2*WIDTH-1:0] out_data_q;

  logic w_hs;
  logic px_hs;
  logic tag_in;
  logic tag_last;

  // Ready flags are only ever raised in their own state, so these are the
  // full handshake conditions.
  assign w_hs   = bus.w_valid  & w_ready_q;
  assign px_hs  = bus.px_valid & px_ready_q;
  assign tag_in = px_hs && (row >= ROW_FIRST) && (col >= COL_FIRST);

  conv_valid_dly #(
    .DEPTH (PE_LAT + 1)
  ) u_valid_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (tag_in),
    .dout  (tag_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      w_cnt       <= '0;
      col         <= '0;
      row         <= '0;
      drain_cnt   <= '0;
      w_ready_q   <= 1'b0;
      px_ready_q  <= 1'b0;
      pe_weight_q <= '0;
      pe_wload_q  <= 1'b0;
      pe_data_q   <= '0;
      pe_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      pe_wload_q  <= 1'b0;
      pe_en_q     <= 1'b0;
      done        <= 1'b0;
      // Tag emerges the cycle the PE result for that pixel is on pe_data_out.
      out_valid_q <= tag_last;
      if (tag_last) out_data_q <= bus.pe_data_out;

      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD_W;
            busy      <= 1'b1;
            w_ready_q <= 1'b1;
            w_cnt     <= '0;
            col       <= '0;
            row       <= '0;
            drain_cnt <= '0;
          end
        end
        LOAD_W: begin
          if (w_hs) begin
            pe_weight_q <= bus.w_data;
            pe_wload_q  <= 1'b1;
            if (w_cnt == W_LAST) begin
              state      <= STREAM;
              w_ready_q  <= 1'b0;
              px_ready_q <= 1'b1;
            end else begin
              w_cnt <= w_cnt + 1'b1;
            end
          end
        end
        STREAM: begin
          if (px_hs) begin
            pe_data_q <= bus.px_data;
            pe_en_q   <= 1'b1;
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                state      <= DRAIN;
                px_ready_q <= 1'b0;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == D_LAST) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign state_dbg        = state;
  assign bus.w_ready      = w_ready_q;
  assign bus.px_ready     = px_ready_q;
  assign bus.pe_weight_in = pe_weight_q;
  assign bus.pe_wload     = pe_wload_q;
  assign bus.pe_data_in   = pe_data_q;
  assign bus.pe_en        = pe_en_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;

endmodule

// File: tb/tb_conv_pe_ctrl.sv
// Bench for conv_pe_ctrl: a scenario table plus random images, checked
// against a raster-order window model and a behavioural PE pipeline.
module tb_conv_pe_ctrl;
  import conv_pkg::*;

  localparam int W      = 9;
  localparam int K      = 3;
  localparam int IMG_W  = 32;
  localparam int IMG_H  = 3;
  localparam int PE_LAT = 2;
  localparam int DW     = 2 * W;
  localparam int KK     = K * K;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NV     = 6;

  typedef struct {
    bit w_toggle;
    bit w_hold;
    bit px_early;
    int stall_idx;
    int stall_len;
    bit rand_px;
    bit start_mid;
    int exp_outs;
    int exp_done;
    int exp_max_gap;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n;
  logic   start;
  logic   busy;
  logic   done;
  state_t state_dbg;

  always #5 clk = ~clk;

  conv_pe_ctrl_if #(.WIDTH(W)) bus ();

  conv_pe_ctrl #(
    .WIDTH (W), .K (K), .IMG_W (IMG_W), .IMG_H (IMG_H), .PE_LAT (PE_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg),
    .bus       (bus)
  );

  // ---------------- PE model ----------------
  function automatic logic [DW-1:0] pe_f(input logic [W-1:0] x);
    return DW'(x) * DW'(3) + DW'(1);
  endfunction

  logic [DW-1:0] pe_pipe [PE_LAT];
  always @(posedge clk) begin
    pe_pipe[0] <= bus.pe_en ? pe_f(bus.pe_data_in) : '1;
    for (int i = 1; i < PE_LAT; i++) pe_pipe[i] <= pe_pipe[i-1];
  end
  assign bus.pe_data_out = pe_pipe[PE_LAT-1];

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [W-1:0]  px_vals [NPIX];
  logic [W-1:0]  w_vals  [KK];
  logic [W-1:0]  got_w[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_v;
  logic [W-1:0]  last_px;
  int cyc = 0;
  int en_cnt, out_cnt, done_cnt, hold_err, max_gap;
  int en22_cyc, last_en_cyc, first_out_cyc, last_out_cyc, done_cyc;
  bit done_prev;

  task automatic reset_mon();
    got_w.delete();
    exp_q.delete();
    en_cnt = 0; out_cnt = 0; done_cnt = 0; hold_err = 0; max_gap = 0;
    en22_cyc = 0; last_en_cyc = 0; first_out_cyc = 0; last_out_cyc = 0; done_cyc = 0;
    done_prev = 1'b0;
    last_px = '0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (bus.pe_wload) got_w.push_back(bus.pe_weight_in);
    if (bus.pe_en) begin
      if (en_cnt == (K-1)*IMG_W + (K-1)) en22_cyc = cyc;
      if (en_cnt > 0 && cyc - last_en_cyc > max_gap) max_gap = cyc - last_en_cyc;
      last_en_cyc = cyc;
      last_px = bus.pe_data_in;
      en_cnt++;
    end else if (busy && en_cnt > 0 && bus.pe_data_in !== last_px) begin
      hold_err++;
    end
    if (bus.out_valid) begin
      if (out_cnt == 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
      out_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_extra: got out_data %0h with no expected result left", bus.out_data);
      end else begin
        exp_v = exp_q.pop_front();
        check("out_data", bus.out_data, exp_v);
      end
    end
    if (done_prev) check("busy_after_done", busy, 1'b0);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check("busy_at_done", busy, 1'b1);
    end
    done_prev = done;
  end

  // ---------------- drivers ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},     state_dbg,        IDLE);
    check({tag, "_busy"},      busy,             1'b0);
    check({tag, "_done"},      done,             1'b0);
    check({tag, "_w_ready"},   bus.w_ready,      1'b0);
    check({tag, "_px_ready"},  bus.px_ready,     1'b0);
    check({tag, "_pe_wload"},  bus.pe_wload,     1'b0);
    check({tag, "_pe_en"},     bus.pe_en,        1'b0);
    check({tag, "_out_valid"}, bus.out_valid,    1'b0);
    check({tag, "_pe_weight"}, bus.pe_weight_in, '0);
    check({tag, "_pe_data"},   bus.pe_data_in,   '0);
    check({tag, "_out_data"},  bus.out_data,     '0);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_weights(input vec_t v);
    int i = 0;
    int bound = 0;
    while (i < KK && bound < 200) begin
      @(negedge clk);
      bus.w_valid = v.w_toggle ? (bound % 2 == 0) : 1'b1;
      bus.w_data  = w_vals[i];
      bus.px_valid = v.px_early;
      bus.px_data  = W'($urandom);
      if (bus.w_valid && bus.w_ready) i++;
      bound++;
    end
    check("w_sent", i, KK);
  endtask

  task automatic send_pixels(input vec_t v, input int abort_at, output bit aborted);
    int idx = 0;
    int bound = 0;
    int stall = 0;
    bit sm_fired = 1'b0;
    aborted = 1'b0;
    while (idx < NPIX && bound < 3000) begin
      @(negedge clk);
      bound++;
      if (v.w_hold) bus.w_data = W'($urandom);
      else          bus.w_valid = 1'b0;
      if (v.start_mid && idx == 50 && !sm_fired) begin
        start = 1'b1;
        sm_fired = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (idx == abort_at) begin
        bus.px_valid = 1'b0;
        rst_n = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (idx == v.stall_idx && stall < v.stall_len) begin
        bus.px_valid = 1'b0;
        bus.px_data  = W'($urandom);
        stall++;
      end else begin
        bus.px_valid = v.rand_px ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.px_data  = bus.px_valid ? px_vals[idx] : W'($urandom);
      end
      if (bus.px_valid && bus.px_ready) idx++;
    end
    @(negedge clk);
    bus.px_valid = 1'b0;
    bus.w_valid  = 1'b0;
    start = 1'b0;
    if (aborted) begin
      check_reset_outputs("abort");
      rst_n = 1'b1;
    end else begin
      check("px_sent", idx, NPIX);
    end
  endtask

  task automatic run_image(input vec_t v, input int abort_at);
    bit aborted;
    reset_mon();
    for (int i = 0; i < KK; i++) w_vals[i] = v.rand_px ? W'($urandom) : W'(1 + i / K + i % K);
    for (int i = 0; i < NPIX; i++) px_vals[i] = v.rand_px ? W'($urandom) : W'((i * 37 + 11) % 512);
    // Reference: one result per pixel whose KxK window fits, in raster order.
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        if (r >= K-1 && c >= K-1) exp_q.push_back(pe_f(px_vals[r*IMG_W + c]));
    pulse_start();
    send_weights(v);
    send_pixels(v, abort_at, aborted);
    if (aborted) return;
    for (int t = 0; t < 100 && done_cnt == 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("out_count", out_cnt, v.exp_outs);
    check("done_count", done_cnt, v.exp_done);
    check("w_count", got_w.size(), KK);
    for (int i = 0; i < KK && i < got_w.size(); i++) check("w_value", got_w[i], w_vals[i]);
    check("en_count", en_cnt, NPIX);
    check("first_out_lat", first_out_cyc - en22_cyc, PE_LAT + 1);
    check("drain_len", done_cyc - last_en_cyc, PE_LAT + 1);
    check("last_out_at_done", last_out_cyc, done_cyc);
    check("pe_data_hold", hold_err, 0);
    if (v.exp_max_gap != 0) check("max_en_gap", max_gap, v.exp_max_gap);
    check("exp_q_empty", exp_q.size(), 0);
    check("busy_idle", busy, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs [NV];
  vec_t rv;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bus.w_valid = 1'b0; bus.w_data = '0;
    bus.px_valid = 1'b0; bus.px_data = '0;
    reset_mon();

    //          tog hold early stall_idx len rnd smid outs done gap
    vecs[0] = '{0,  0,   0,    -1,       0,  0,  0,   30,  1,   1};
    vecs[1] = '{0,  0,   0,    74,       5,  0,  0,   30,  1,   6};
    vecs[2] = '{1,  1,   1,    -1,       0,  0,  0,   30,  1,   1};
    vecs[3] = '{0,  0,   0,    -1,       0,  0,  1,   30,  1,   1};
    vecs[4] = '{0,  0,   0,    -1,       0,  1,  0,   30,  1,   0};
    vecs[5] = '{1,  1,   1,    -1,       0,  1,  1,   30,  1,   0};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    for (int n = 0; n < NV; n++) run_image(vecs[n], -1);

    // Reset after 40 pixels: abort with no done, then a clean image.
    run_image(vecs[0], 40);
    repeat (5) @(negedge clk);
    check("abort_done", done_cnt, 0);
    check("abort_outs", out_cnt, 0);
    check("abort_busy", busy, 1'b0);
    run_image(vecs[0], -1);

    for (int n = 0; n < 3; n++) begin
      rv = '{$urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, NPIX - 1), $urandom_range(1, 8), 1, $urandom_range(0, 1),
             30, 1, 0};
      run_image(rv, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
